// File: rtl/rt_pkg.sv
// Shared types and constants for the raytracer frame sequencer.
package rt_pkg;
  localparam int unsigned COORD_W       = 16;
  localparam int unsigned STAT_ERR_BIT  = 31;
  localparam int unsigned STAT_SPUR_BIT = 30;
  localparam int unsigned STAT_CYC_W    = 30;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } rt_seq_state_t;
endpackage

// File: rtl/rt_raster_cnt.sv
// Raster-order pixel coordinate counter: x first, wrapping into y.
module rt_raster_cnt
  import rt_pkg::*;
#(
  parameter int unsigned XRES = 640,
  parameter int unsigned YRES = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(XRES - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(YRES - 1);

  assign last = (x == XMAX) && (y == YMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == XMAX) begin
        x <= '0;
        y <= (y == YMAX) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end
endmodule

// File: rtl/rt_frame_seq.sv
// Frame sequencer: issues pixel requests in raster order under a credit
// limit, drains completions and reports a frame status word.
module rt_frame_seq
  import rt_pkg::*;
#(
  parameter int unsigned XRES   = 640,
  parameter int unsigned YRES   = 480,
  parameter int unsigned MAXOUT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_rt,
  output logic               busy,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  input  logic               done_valid,
  input  logic               done_err,
  output logic               end_rt,
  output logic [31:0]        end_rtstat
);
  localparam int unsigned          OUT_W   = $clog2(MAXOUT + 1);
  localparam logic [OUT_W-1:0]     OUT_MAX = OUT_W'(MAXOUT);

  rt_seq_state_t           state, state_nx;
  logic [OUT_W-1:0]        outs, outs_nx;
  logic [STAT_CYC_W-1:0]   cyc, cyc_nx;
  logic                    err, err_nx, spur, spur_nx;
  logic                    frame_start, counting, done_ok, accept, last;
  logic [31:0]             stat_nx;

  assign frame_start = (state == IDLE) && start_rt;
  assign counting    = (state == ISSUE) || (state == DRAIN);
  assign done_ok     = counting && done_valid;
  assign px_valid    = (state == ISSUE) && (outs < OUT_MAX);
  assign accept      = px_valid && px_ready;
  assign busy        = (state != IDLE);
  assign end_rt      = (state == DONE);

  rt_raster_cnt #(.XRES(XRES), .YRES(YRES)) u_raster (
    .clk     (clk),
    .reset   (reset),
    .clear   (frame_start),
    .advance (accept),
    .x       (px_x),
    .y       (px_y),
    .last    (last)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_rt) state_nx = ISSUE;
      ISSUE:   if (accept && last) state_nx = DRAIN;
      DRAIN:   if (outs == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    outs_nx = outs;
    if (accept && !done_ok)
      outs_nx = outs + 1'b1;
    else if (!accept && done_ok && (outs != '0))
      outs_nx = outs - 1'b1;
    spur_nx = spur | (done_ok && !accept && (outs == '0));
    err_nx  = err | (done_ok && done_err);
    cyc_nx  = cyc;
    if (counting && (cyc != '1))
      cyc_nx = cyc + 1'b1;
    // Status captures the final cycle's updates, not the registered values.
    stat_nx                   = '0;
    stat_nx[STAT_ERR_BIT]     = err_nx;
    stat_nx[STAT_SPUR_BIT]    = spur_nx;
    stat_nx[STAT_CYC_W-1:0]   = cyc_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      outs       <= '0;
      cyc        <= '0;
      err        <= 1'b0;
      spur       <= 1'b0;
      end_rtstat <= '0;
    end else begin
      state <= state_nx;
      if (frame_start) begin
        outs <= '0;
        cyc  <= '0;
        err  <= 1'b0;
        spur <= 1'b0;
      end else begin
        outs <= outs_nx;
        cyc  <= cyc_nx;
        err  <= err_nx;
        spur <= spur_nx;
      end
      if ((state == DRAIN) && (outs == '0))
        end_rtstat <= stat_nx;
    end
  end
endmodule

// File: tb/tb_rt_frame_seq.sv
// Scoreboard bench for rt_frame_seq: two instances (2x1/2 and 4x1/2).
module tb_rt_frame_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_a, ready_a, done_a, err_a;
  logic        busy_a, valid_a, end_a;
  logic [15:0] x_a, y_a;
  logic [31:0] stat_a;

  logic        start_b, ready_b, done_b, err_b;
  logic        busy_b, valid_b, end_b;
  logic [15:0] x_b, y_b;
  logic [31:0] stat_b;

  rt_frame_seq #(.XRES(2), .YRES(1), .MAXOUT(2)) dut_a (
    .clk(clk), .reset(reset), .start_rt(start_a), .busy(busy_a),
    .px_valid(valid_a), .px_ready(ready_a), .px_x(x_a), .px_y(y_a),
    .done_valid(done_a), .done_err(err_a), .end_rt(end_a), .end_rtstat(stat_a)
  );

  rt_frame_seq #(.XRES(4), .YRES(1), .MAXOUT(2)) dut_b (
    .clk(clk), .reset(reset), .start_rt(start_b), .busy(busy_b),
    .px_valid(valid_b), .px_ready(ready_b), .px_x(x_b), .px_y(y_b),
    .done_valid(done_b), .done_err(err_b), .end_rt(end_b), .end_rtstat(stat_b)
  );

  int total = 0;
  int bad   = 0;
  int ends_a = 0, ends_b = 0, acc_b = 0;
  logic [31:0] pxq_a[$], stq_a[$], pxq_b[$], stq_b[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      chk("a_px_pending", pxq_a.size() != 0, 1);
      if (pxq_a.size() != 0) chk("a_px", {y_a, x_a}, pxq_a.pop_front());
    end
    if (end_a) begin
      ends_a++;
      chk("a_end_expected", stq_a.size() != 0, 1);
      if (stq_a.size() != 0) chk("a_stat", stat_a, stq_a.pop_front());
    end
    if (valid_b && ready_b) begin
      acc_b++;
      chk("b_px_pending", pxq_b.size() != 0, 1);
      if (pxq_b.size() != 0) chk("b_px", {y_b, x_b}, pxq_b.pop_front());
    end
    if (end_b) begin
      ends_b++;
      chk("b_end_expected", stq_b.size() != 0, 1);
      if (stq_b.size() != 0) chk("b_stat", stat_b, stq_b.pop_front());
    end
  end

  // s: stall cycles, e: error on first done, extra: spurious done, poke: start while busy
  task automatic frame_a(input int s, input bit e, input bit extra, input bit poke);
    logic [31:0] exp_stat;
    exp_stat = {e, extra, 30'(s + 6)};
    pxq_a.push_back({16'd0, 16'd0});
    pxq_a.push_back({16'd0, 16'd1});
    stq_a.push_back(exp_stat);
    start_a = 1'b1;
    ready_a = (s == 0);
    tick;                                  // c1
    start_a = 1'b0;
    chk("a_lat_valid", valid_a, 1);
    chk("a_lat_xy", {y_a, x_a}, 0);
    for (int i = 1; i <= s; i++) begin
      chk("a_bp_valid", valid_a, 1);
      chk("a_bp_xy", {y_a, x_a}, 0);
      tick;
    end
    ready_a = 1'b1;                        // c(s+1): accept (0,0)
    tick;                                  // c(s+2)
    start_a = poke;
    chk("a_x1", {y_a, x_a}, {16'd0, 16'd1});
    tick;                                  // c(s+3): DRAIN
    start_a = 1'b0;
    ready_a = 1'b0;
    chk("a_drain_valid", valid_a, 0);
    chk("a_drain_busy", busy_a, 1);
    tick;                                  // c(s+4)
    done_a = 1'b1;
    err_a  = e;
    tick;                                  // c(s+5)
    err_a   = 1'b0;
    start_a = poke;
    tick;                                  // c(s+6)
    start_a = 1'b0;
    done_a  = extra;
    tick;                                  // c(s+7): DONE
    done_a = 1'b0;
    chk("a_end", end_a, 1);
    tick;
    chk("a_end_pulse", end_a, 0);
    chk("a_idle_busy", busy_a, 0);
    chk("a_stat_hold", stat_a, exp_stat);
    tick;
    chk("a_stat_hold2", stat_a, exp_stat);
  endtask

  task automatic frame_b;
    for (int i = 0; i < 4; i++) pxq_b.push_back({16'd0, 16'(i)});
    stq_b.push_back(32'd10);
    start_b = 1'b1;
    ready_b = 1'b1;
    tick;                                  // c1
    start_b = 1'b0;
    tick;                                  // c2
    tick;                                  // c3
    chk("b_stall_valid", valid_b, 0);
    chk("b_accepts", acc_b, 2);
    tick;                                  // c4
    chk("b_stall_valid2", valid_b, 0);
    done_b = 1'b1;
    tick;                                  // c5
    done_b = 1'b0;
    chk("b_resume_valid", valid_b, 1);
    chk("b_resume_xy", {y_b, x_b}, {16'd0, 16'd2});
    tick;                                  // c6
    chk("b_stall_valid3", valid_b, 0);
    done_b = 1'b1;
    tick;                                  // c7
    done_b = 1'b0;
    chk("b_last_xy", {y_b, x_b}, {16'd0, 16'd3});
    tick;                                  // c8: DRAIN
    done_b = 1'b1;
    tick;                                  // c9
    tick;                                  // c10
    done_b = 1'b0;
    tick;                                  // c11
    chk("b_end", end_b, 1);
    tick;
    chk("b_idle", busy_b, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    {start_a, ready_a, done_a, err_a} = '0;
    {start_b, ready_b, done_b, err_b} = '0;
    #3;
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_xy", {y_a, x_a}, 0);
    chk("rst_end", end_a, 0);
    chk("rst_stat", stat_a, 0);
    tick;
    tick;
    reset = 1'b1;

    frame_a(0, 1'b0, 1'b0, 1'b0);          // basic frame: status 6
    frame_b;                               // credit stall
    frame_a(5, 1'b0, 1'b0, 1'b0);          // backpressure: status 11
    frame_a(0, 1'b1, 1'b0, 1'b0);          // error flag
    frame_a(0, 1'b0, 1'b1, 1'b0);          // spurious completion
    done_a = 1'b1;                         // done in IDLE is ignored
    tick;
    done_a = 1'b0;
    tick;
    frame_a(0, 1'b0, 1'b0, 1'b1);          // start pulses while busy

    // reset in DRAIN abandons the frame
    pxq_a.push_back({16'd0, 16'd0});
    pxq_a.push_back({16'd0, 16'd1});
    start_a = 1'b1;
    ready_a = 1'b1;
    tick;
    start_a = 1'b0;
    tick;
    tick;
    chk("mid_drain_busy", busy_a, 1);
    ready_a = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_stat", stat_a, 0);
    chk("mid_rst_end", end_a, 0);
    chk("mid_rst_valid", valid_a, 0);
    repeat (3) tick;
    reset = 1'b1;
    repeat (8) tick;
    chk("mid_rst_idle", busy_a, 0);
    frame_a(0, 1'b0, 1'b0, 1'b0);

    chk("a_end_count", ends_a, 6);
    chk("b_end_count", ends_b, 1);
    chk("a_pxq_left", pxq_a.size(), 0);
    chk("a_stq_left", stq_a.size(), 0);
    chk("b_pxq_left", pxq_b.size(), 0);
    chk("b_stq_left", stq_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rt_frame_seq.md
RT_FRAME_SEQ -- requirements
Module: rt_frame_seq

Interface
REQ-001 SHALL have parameters: XRES default 640, horizontal pixel count (1..65535); YRES default 480, vertical pixel count (1..65535); MAXOUT default 8, max outstanding pixels (1..255).
REQ-002 SHALL have ports, in order:
- clk  in  1  single clock, all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_rt  in  1  one-cycle frame-start pulse from the Avalon control slave.
- busy  out  1  frame in progress.
- px_valid  out  1  pixel request valid to the raytracer core.
- px_ready  in  1  core accepts the request.
- px_x  out  16  request column.
- px_y  out  16  request row.
- done_valid  in  1  one-cycle pulse: one pixel completed.
- done_err  in  1  that completion failed; qualified by done_valid.
- end_rt  out  1  one-cycle frame-complete pulse to the control slave.
- end_rtstat  out  32  frame status word; valid when end_rt is high and held afterwards.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-004 IDLE: on start_rt, SHALL go to ISSUE next cycle and clear px_x, px_y, the outstanding count, the cycle counter and the error flags.
REQ-005 start_rt outside IDLE SHALL be ignored, with no effect on any state.
REQ-006 busy SHALL be 1 in every state except IDLE.
REQ-007 ISSUE: px_valid SHALL be 1 iff outstanding < MAXOUT.
REQ-008 Once px_valid is 1, it and px_x/px_y SHALL hold until px_valid&&px_ready.
REQ-009 Raster order: px_x increments first; it wraps from XRES-1 to 0 with px_y+1.
REQ-010 An accept of (XRES-1, YRES-1) SHALL move to DRAIN next cycle and drop px_valid.
REQ-011 Outstanding count: +1 on accept, -1 on done_valid, unchanged when both occur in the same cycle; width is clog2(MAXOUT+1).
REQ-012 done_valid with outstanding == 0 (and no same-cycle accept) SHALL leave the count at 0 and set the sticky flag spur.
REQ-013 done_valid&&done_err SHALL set the sticky flag err.
REQ-014 DRAIN: when the registered outstanding count == 0, SHALL go to DONE next cycle.
REQ-015 DONE lasts one cycle: end_rt = 1, then IDLE.
REQ-016 end_rtstat SHALL be registered on DONE entry: [31]=err, [30]=spur, [29:0]=cycle counter.
REQ-017 end_rtstat SHALL hold until the next DONE.
REQ-018 The cycle counter SHALL increment on every ISSUE and DRAIN cycle and saturate at 2^30-1.
REQ-019 done_valid in IDLE or DONE SHALL be ignored; spur is not set.
REQ-020 Latency: start_rt in cycle N gives px_valid=1 with (0,0) in cycle N+1.

Reset
REQ-021 While reset=0, the block SHALL asynchronously force: state IDLE, busy 0, px_valid 0, px_x 0, px_y 0, end_rt 0, end_rtstat 0, all counters and flags 0.
REQ-022 Reset mid-frame SHALL abandon the frame without producing end_rt.
REQ-023 After reset, the block SHALL accept start_rt on the first clock edge with reset=1.

Structure
REQ-024 A shared package rt_pkg SHALL hold:
- the FSM state enum rt_seq_state_t;
- the status bit positions STAT_ERR_BIT=31 and STAT_SPUR_BIT=30, and STAT_CYC_W=30;
- COORD_W=16.
REQ-025 SHALL contain one sub-module, rt_raster_cnt: a coordinate counter with advance, clear and last outputs.
REQ-026 All other logic (FSM, credit counter, status) SHALL live in rt_frame_seq.

Verification (XRES=2, YRES=1, MAXOUT=2 unless noted)
REQ-027 Basic frame: start_rt at c0, px_ready=1, done_valid at c4 and c5.
- Required: px (0,0) at c1, (1,0) at c2; end_rt at c7; end_rtstat=0x00000006.
REQ-028 Credit stall (XRES=4, MAXOUT=2): px_ready=1 and no done.
- Required: exactly 2 accepts, then px_valid=0.
- After one done_valid: px_valid=1 next cycle with (2,0).
REQ-029 Backpressure: px_ready=0 for 5 cycles after c1.
- Required: px_valid and (0,0) stable throughout; cycle count in end_rtstat increases by 5.
REQ-030 Errors:
- done_err with one done: end_rtstat[31]=1.
- An extra done_valid in DRAIN with outstanding 0: end_rtstat[30]=1.
- Both flags clear on the next start_rt.
REQ-031 Start while busy in ISSUE: no restart and coordinates unaffected; the frame completes exactly once.
REQ-032 Reset mid-frame: reset=0 in DRAIN.
- Required: busy=0 and end_rtstat=0 immediately; no end_rt.
- A new start_rt afterwards yields a full normal frame.
